// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA pipeline CPU execute-stage arithmetic.
// Contents:
//   state_t     - sequencer state encoding used by the multi-cycle units
//   W_DEFAULT   - default datapath width
//   ALU_MODMUL  - ALUControl code decoded upstream into start_i of ex_modmul_unit
package rsa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int W_DEFAULT = 32;

  localparam logic [3:0] ALU_MODMUL = 4'b1010;

endpackage

// File: rtl/modred_step.sv
// One interleaved modular-multiplication step, purely combinational:
//   acc_o = (2*acc_i + addend_i) reduced by up to two subtractions of n_i.
// With acc_i < n_i and addend_i < n_i the sum stays below 3n, so two
// conditional subtracts always bring the result back below n_i.
// Ports:
//   acc_i    in  W+2  accumulator entering the step
//   addend_i in  W    value added after doubling (b or 0)
//   n_i      in  W    modulus
//   acc_o    out W+2  reduced accumulator, < n_i
module modred_step #(
  parameter int W = 32
) (
  input  logic [W+1:0] acc_i,
  input  logic [W-1:0] addend_i,
  input  logic [W-1:0] n_i,
  output logic [W+1:0] acc_o
);

  logic [W+1:0] n_ext;
  logic [W+1:0] sum;
  logic [W+1:0] sub1;

  always_comb begin
    n_ext = {2'b00, n_i};
    sum   = (acc_i << 1) + {2'b00, addend_i};
    sub1  = (sum >= n_ext) ? (sum - n_ext) : sum;
    acc_o = (sub1 >= n_ext) ? (sub1 - n_ext) : sub1;
  end

endmodule

// File: rtl/ex_modmul_unit.sv
// Multi-cycle modular multiplier for the execute stage.
// Computes (a_i * b_i) mod n_i by MSB-first shift-add-reduce, one bit of a
// per cycle, stalling the pipeline while busy.
// Ports:
//   clk, rst  clock (rising edge) and asynchronous active-high reset
//   start_i   operation request, honoured only in IDLE
//   flush_i   abort current operation (branch flush)
//   a_i, b_i  operands, must be < n_i
//   n_i       modulus, must be non-zero
//   result_o  registered result, updated on entry to DONE
//   done_o    one-cycle completion pulse
//   err_o     qualifies done_o: operands were illegal
//   stall_o   hold the E stage
module ex_modmul_unit
  import rsa_pkg::*;
#(
  parameter int W  = W_DEFAULT,
  parameter int CW = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic         flush_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] n_i,
  output logic [W-1:0] result_o,
  output logic         done_o,
  output logic         err_o,
  output logic         stall_o
);

  state_t        state_q, state_d;
  logic [W+1:0]  acc_q, acc_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  n_q, n_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  result_q, result_d;
  logic          err_q, err_d;

  logic [W-1:0]  addend;
  logic [W+1:0]  step_acc;

  assign addend = a_q[cnt_q] ? b_q : '0;

  modred_step #(.W(W)) u_step (
    .acc_i    (acc_q),
    .addend_i (addend),
    .n_i      (n_q),
    .acc_o    (step_acc)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    a_d      = a_q;
    b_d      = b_q;
    n_d      = n_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    err_d    = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i && !flush_i) begin
          if ((n_i == '0) || (a_i >= n_i) || (b_i >= n_i)) begin
            // Illegal operands complete immediately with an error
            state_d  = ST_DONE;
            err_d    = 1'b1;
            result_d = '0;
          end else begin
            state_d = ST_RUN;
            a_d     = a_i;
            b_d     = b_i;
            n_d     = n_i;
            acc_d   = '0;
            cnt_d   = CW'(W - 1);
          end
        end
      end
      ST_RUN: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = step_acc;
          if (cnt_q == '0) begin
            // Result is captured on entry to DONE so it is valid with done_o
            state_d  = ST_DONE;
            result_d = step_acc[W-1:0];
            err_d    = 1'b0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      n_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      n_q      <= n_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign result_o = result_q;
  assign err_o    = err_q;
  // A flush landing in DONE swallows the completion pulse
  assign done_o   = (state_q == ST_DONE) && !flush_i;
  assign stall_o  = ((state_q == ST_IDLE) && start_i) || (state_q == ST_RUN);

endmodule
